apb_reg_bank: RTL and testbench
===============================

# apb_reg_bank

Parametrised APB3/APB4 register bank that replaces the single control register with a multi-channel bank. It sits between the PS APB bridge and NUM_CH tile codec channels. Per channel it provides tile geometry, encode/decode mode and a start pulse, and it captures encoded byte length. It adds sticky W1C done/overflow status, byte-strobe writes, an interrupt output and address-error reporting.

## Interface
- DATA_WIDTH, 32, APB data width; fixed at 32, other values unsupported.
- ADDR_WIDTH, 32, APB address width.
- BASE_ADDR, 32'h43C00000, bank base; decoded offset = paddr - BASE_ADDR.
- NUM_CH, 4, channel count, 1..8.
- LEN_W, 12, byte-length field width, 1..16.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_apb_paddr / psel / penable / pwrite / pprot[2:0] / pstrb[3:0] / pwdata[31:0]  in  APB requester signals; pprot is ignored.
- s_apb_prdata  out  32  read data.
- s_apb_pready  out  1  tied 1 (zero wait states).
- s_apb_pslverr  out  1  access error.
- encode_done  in  NUM_CH  per-channel one-cycle completion pulse.
- byte_len  in  NUM_CH*LEN_W  per-channel length; sampled on encode_done.
- tile_width  out  NUM_CH*9  per-channel CH_CFG[31:23].
- tile_height  out  NUM_CH*9  per-channel CH_CFG[22:14].
- en_or_de  out  NUM_CH  per-channel CH_CFG[0].
- ch_start  out  NUM_CH  one-cycle start pulses.
- irq  out  1  level interrupt.

## Operation
- Register map. All offsets are word-aligned.
  - 0x00 CTRL (RW): bit0 = global enable. Bits[8+NUM_CH-1:8] = start, write-1-self-clearing, always read 0.
  - 0x04 STATUS: bits[NUM_CH-1:0] = done (W1C). Bits[8+NUM_CH-1:8] = ovf (W1C).
  - 0x08 IRQ_EN (RW): bits[NUM_CH-1:0] enable interrupts.
  - 0x10+8*ch CH_CFG (RW, 32 bits).
  - 0x14+8*ch CH_LEN (RO): bits[LEN_W-1:0] = last captured length.
- Write: happens in the access phase (psel & penable & pwrite). Byte lane i is updated only when pstrb[i]=1. W1C and start bits also obey pstrb.
- Start pulse: a CTRL write with global enable = 1 (new or already set) and start bit ch = 1 drives ch_start[ch]=1 for exactly the next cycle. With enable = 0, no pulse is generated.
- encode_done[ch]:
  - Sets done[ch] and loads CH_LEN[ch] from byte_len.
  - If done[ch] is already 1, it also sets ovf[ch]; CH_LEN is still overwritten.
- Same-cycle W1C and encode_done on the same bit: the set wins and the bit stays 1.
- irq = |(done & IRQ_EN), registered.
- Read: prdata is loaded in the setup phase (psel & ~penable & ~pwrite) and held until the next read setup. Unmapped offsets read 0.
- Reserved bits read 0 and ignore writes.
- Error condition: offset outside the map, offset not word-aligned, or a write to CH_LEN. A write with an error has no effect.

## Timing
- Reset values: all registers 0, prdata 0, pslverr 0, ch_start 0, irq 0. Outputs derived from CH_CFG are therefore 0.
- Reset asserted mid-transfer aborts the transfer. Status and pulses clear the same edge.
- Write latency: the register value is visible on outputs 1 cycle after the access-phase edge.
- ch_start latency: asserted 1 cycle after the access-phase edge, for 1 cycle.
- Read data: valid throughout the access phase, since pready=1 and each transfer takes 2 cycles.
- STATUS/CH_LEN capture: encode_done at edge N is readable by a read whose setup phase is at edge N+1 or later.
- irq latency: rises 1 cycle after done or IRQ_EN is set. Falls 1 cycle after the clearing write.
- pslverr: combinational from psel & penable & the decoded error. Asserted only in the access phase.

## Configuration
- APB_REG_BANK_PSLVERR_EN defined: pslverr is driven per the error rules above.
- Not defined: pslverr is tied 0. Bad writes are silently ignored and bad reads return 0. Decode logic for aligned/unmapped offsets remains.

## Test plan
- Reset then read all mapped offsets -> every read is 0 and pslverr=0.
- Write CH_CFG[1]=32'hFF00_C001 with pstrb=4'b0011, then read back -> 32'h0000_C001.
  - ch1 outputs: tile_width=0, tile_height=9'h003, en_or_de[1]=1.
- Write CTRL=32'h0000_0401 (enable, start ch2) -> ch_start=4'b0100 for one cycle.
  - Then write CTRL=32'h0000_0400 -> no pulse.
- Pulse encode_done[0] with byte_len[0]=12'h1A3, IRQ_EN=1:
  - irq=1, STATUS=0x1, CH_LEN[0]=0x1A3.
  - A second done -> STATUS=0x101.
  - Write STATUS=0x101 -> STATUS=0, irq=0.
- W1C of done[3] in the same cycle as encode_done[3] -> done[3] remains 1.
- With the macro defined:
  - Write to 0x14 -> pslverr=1, CH_LEN unchanged.
  - Read 0x100 -> pslverr=1, prdata=0.
  - Read 0x02 -> pslverr=1.
- Without the macro: the same three accesses give pslverr=0.

Source files
------------

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB3/APB4 multi-channel register bank for tile codec channels.
// Define APB_REG_BANK_PSLVERR_EN to report bad accesses on pslverr.
module apb_reg_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h43C0_0000,
    parameter int                    NUM_CH     = 4,
    parameter int                    LEN_W      = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     s_apb_paddr,
    input  logic                      s_apb_psel,
    input  logic                      s_apb_penable,
    input  logic                      s_apb_pwrite,
    input  logic [2:0]                s_apb_pprot,
    input  logic [DATA_WIDTH/8-1:0]   s_apb_pstrb,
    input  logic [DATA_WIDTH-1:0]     s_apb_pwdata,
    output logic [DATA_WIDTH-1:0]     s_apb_prdata,
    output logic                      s_apb_pready,
    output logic                      s_apb_pslverr,
    input  logic [NUM_CH-1:0]         encode_done,
    input  logic [NUM_CH*LEN_W-1:0]   byte_len,
    output logic [NUM_CH*9-1:0]       tile_width,
    output logic [NUM_CH*9-1:0]       tile_height,
    output logic [NUM_CH-1:0]         en_or_de,
    output logic [NUM_CH-1:0]         ch_start,
    output logic                      irq
);

    logic [ADDR_WIDTH-1:0] off;
    logic aligned, mapped, bank_err;
    logic hit_ctrl, hit_stat, hit_ien;
    logic [NUM_CH-1:0] hit_cfg, hit_len;
    logic access, setup, wr_en;
    logic [31:0] bmask, rdata;

    logic en_q, en_d, irq_q;
    logic [NUM_CH-1:0] ien_q, ien_d, done_q, done_d, ovf_q, ovf_d;
    logic [NUM_CH-1:0] start_q, start_d, done_clr, ovf_clr;
    logic [NUM_CH-1:0][31:0] cfg_q, cfg_d;
    logic [NUM_CH-1:0][LEN_W-1:0] len_q, len_d;
    logic [31:0] prdata_q;

    logic unused_pprot;
    assign unused_pprot = ^s_apb_pprot;

    assign off      = s_apb_paddr - BASE_ADDR;
    assign aligned  = off[1:0] == 2'b00;
    assign hit_ctrl = off == ADDR_WIDTH'(0);
    assign hit_stat = off == ADDR_WIDTH'(4);
    assign hit_ien  = off == ADDR_WIDTH'(8);

    always_comb begin
        hit_cfg = '0;
        hit_len = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit_cfg[c] = off == ADDR_WIDTH'(16 + 8 * c);
            hit_len[c] = off == ADDR_WIDTH'(20 + 8 * c);
        end
    end

    assign mapped   = aligned & (hit_ctrl | hit_stat | hit_ien
                                 | (|hit_cfg) | (|hit_len));
    // CH_LEN is capture-only, so a write there is an error
    assign bank_err = ~mapped | (s_apb_pwrite & (|hit_len));
    assign access   = s_apb_psel & s_apb_penable;
    assign setup    = s_apb_psel & ~s_apb_penable;
    assign wr_en    = access & s_apb_pwrite & ~bank_err;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < 4; b++)
            bmask[8*b +: 8] = {8{s_apb_pstrb[b]}};
    end

    always_comb begin
        en_d     = en_q;
        ien_d    = ien_q;
        start_d  = '0;
        done_clr = '0;
        ovf_clr  = '0;
        cfg_d    = cfg_q;
        len_d    = len_q;
        if (wr_en & hit_ctrl) begin
            if (s_apb_pstrb[0]) en_d = s_apb_pwdata[0];
            if (en_d & s_apb_pstrb[1]) start_d = s_apb_pwdata[8 +: NUM_CH];
        end
        if (wr_en & hit_stat) begin
            if (s_apb_pstrb[0]) done_clr = s_apb_pwdata[0 +: NUM_CH];
            if (s_apb_pstrb[1]) ovf_clr = s_apb_pwdata[8 +: NUM_CH];
        end
        if (wr_en & hit_ien & s_apb_pstrb[0])
            ien_d = s_apb_pwdata[0 +: NUM_CH];
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en & hit_cfg[c])
                cfg_d[c] = (cfg_q[c] & ~bmask) | (s_apb_pwdata[31:0] & bmask);
            if (encode_done[c])
                len_d[c] = byte_len[c*LEN_W +: LEN_W];
        end
        // a completion in the same cycle as its W1C keeps the bit set
        done_d = (done_q & ~done_clr) | encode_done;
        ovf_d  = (ovf_q & ~ovf_clr) | (encode_done & done_q);
    end

    always_comb begin
        rdata = '0;
        if (hit_ctrl) rdata[0] = en_q;
        if (hit_stat) begin
            rdata[0 +: NUM_CH] = done_q;
            rdata[8 +: NUM_CH] = ovf_q;
        end
        if (hit_ien) rdata[0 +: NUM_CH] = ien_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit_cfg[c]) rdata = cfg_q[c];
            if (hit_len[c]) rdata[LEN_W-1:0] = len_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            ien_q    <= '0;
            done_q   <= '0;
            ovf_q    <= '0;
            start_q  <= '0;
            irq_q    <= 1'b0;
            cfg_q    <= '0;
            len_q    <= '0;
            prdata_q <= '0;
        end else begin
            en_q    <= en_d;
            ien_q   <= ien_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            start_q <= start_d;
            irq_q   <= |(done_q & ien_q);
            cfg_q   <= cfg_d;
            len_q   <= len_d;
            if (setup & ~s_apb_pwrite) prdata_q <= rdata;
        end
    end

    always_comb begin
        tile_width  = '0;
        tile_height = '0;
        en_or_de    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tile_width[9*c +: 9]  = cfg_q[c][31:23];
            tile_height[9*c +: 9] = cfg_q[c][22:14];
            en_or_de[c]           = cfg_q[c][0];
        end
    end

    assign s_apb_prdata = DATA_WIDTH'(prdata_q);
    assign s_apb_pready = 1'b1;
    assign ch_start     = start_q;
    assign irq          = irq_q;

`ifdef APB_REG_BANK_PSLVERR_EN
    assign s_apb_pslverr = access & bank_err;
`else
    assign s_apb_pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb_apb_reg_bank: directed vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_apb_reg_bank;
    localparam logic [31:0] BASE = 32'h43C0_0000;
`ifdef APB_REG_BANK_PSLVERR_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]  pprot = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [3:0]  encode_done = '0;
    logic [47:0] byte_len = '0;
    logic [35:0] tile_width, tile_height;
    logic [3:0]  en_or_de, ch_start;
    logic        irq;

    always #5 clk = ~clk;

    apb_reg_bank dut (
        .clk(clk), .rst(rst),
        .s_apb_paddr(paddr), .s_apb_psel(psel),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_pprot(pprot), .s_apb_pstrb(pstrb),
        .s_apb_pwdata(pwdata), .s_apb_prdata(prdata),
        .s_apb_pready(pready), .s_apb_pslverr(pslverr),
        .encode_done(encode_done), .byte_len(byte_len),
        .tile_width(tile_width), .tile_height(tile_height),
        .en_or_de(en_or_de), .ch_start(ch_start), .irq(irq)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic apb_wr(input logic [31:0] off, input logic [31:0] d,
                          input logic [3:0] s, output logic err,
                          output logic [3:0] st);
        @(negedge clk);
        paddr = BASE + off; pwdata = d; pstrb = s;
        pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        st = ch_start;
    endtask

    task automatic apb_rd(input logic [31:0] off, output logic [31:0] d,
                          output logic err);
        @(negedge clk);
        paddr = BASE + off; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] m, input logic [47:0] bl);
        @(negedge clk);
        encode_done = m; byte_len = bl;
        @(negedge clk);
        encode_done = '0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] off;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        bit          err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit wr, input logic [31:0] off,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [31:0] exp, input bit err);
        vec_t v;
        v.wr = wr; v.off = off; v.data = data;
        v.strb = strb; v.exp = exp; v.err = err;
        tbl.push_back(v);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [3:0]  st;

    initial begin
        add(0, 32'h00, 0, 0, 32'h0, 0);
        add(0, 32'h04, 0, 0, 32'h0, 0);
        add(0, 32'h08, 0, 0, 32'h0, 0);
        for (int c = 0; c < 4; c++) begin
            add(0, 32'h10 + 8 * c, 0, 0, 32'h0, 0);
            add(0, 32'h14 + 8 * c, 0, 0, 32'h0, 0);
        end
        add(1, 32'h18, 32'hFF00_C001, 4'b0011, 0, 0);
        add(0, 32'h18, 0, 0, 32'h0000_C001, 0);
        add(1, 32'h14, 32'h0000_0123, 4'b1111, 0, 1);
        add(0, 32'h14, 0, 0, 32'h0, 0);
        add(0, 32'h100, 0, 0, 32'h0, 1);
        add(0, 32'h02, 0, 0, 32'h0, 1);
        add(0, 32'h0C, 0, 0, 32'h0, 1);
        add(1, 32'h08, 32'hFFFF_FFFF, 4'b0001, 0, 0);
        add(0, 32'h08, 0, 0, 32'h0000_000F, 0);
        add(1, 32'h04, 32'hFFFF_FFFF, 4'b1111, 0, 0);
        add(0, 32'h04, 0, 0, 32'h0, 0);
        add(1, 32'h00, 32'hFFFF_FFFF, 4'b0001, 0, 0);
        add(0, 32'h00, 0, 0, 32'h0000_0001, 0);
        add(1, 32'h10, 32'hFFFF_FFFF, 4'b1000, 0, 0);
        add(0, 32'h10, 0, 0, 32'hFF00_0000, 0);

        repeat (3) @(negedge clk);
        chk("rst_prdata", prdata, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_pready", pready, 1);
        chk("rst_ch_start", ch_start, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tile_w", tile_width, 0);
        chk("rst_tile_h", tile_height, 0);
        chk("rst_en_or_de", en_or_de, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                apb_wr(tbl[i].off, tbl[i].data, tbl[i].strb, er, st);
                chk($sformatf("v%0d_wr_err", i), er, tbl[i].err & PE);
                chk($sformatf("v%0d_wr_start", i), st, 0);
            end else begin
                apb_rd(tbl[i].off, rd, er);
                chk($sformatf("v%0d_rd_data", i), rd, tbl[i].exp);
                chk($sformatf("v%0d_rd_err", i), er, tbl[i].err & PE);
            end
        end

        chk("ch1_tile_w", tile_width[17:9], 9'h000);
        chk("ch1_tile_h", tile_height[17:9], 9'h003);
        chk("ch0_tile_w", tile_width[8:0], 9'h1FE);
        chk("ch0_tile_h", tile_height[8:0], 9'h000);
        chk("en_or_de", en_or_de, 4'b0010);

        apb_wr(32'h00, 32'h0000_0401, 4'b1111, er, st);
        chk("start_ch2", st, 4'b0100);
        @(negedge clk);
        chk("start_ch2_1cyc", ch_start, 0);
        apb_wr(32'h00, 32'h0000_0800, 4'b0010, er, st);
        chk("start_ch3_en_kept", st, 4'b1000);
        apb_wr(32'h00, 32'h0000_0400, 4'b1111, er, st);
        chk("start_dis", st, 0);
        apb_rd(32'h00, rd, er);
        chk("ctrl_rd", rd, 0);

        pulse_done(4'b0001, 48'h000_000_000_1A3);
        chk("irq_pre", irq, 0);
        @(negedge clk);
        chk("irq_rise", irq, 1);
        apb_rd(32'h04, rd, er);
        chk("stat_done0", rd, 32'h0000_0001);
        apb_rd(32'h14, rd, er);
        chk("len0_1a3", rd, 32'h0000_01A3);
        pulse_done(4'b0001, 48'h000_000_000_055);
        apb_rd(32'h04, rd, er);
        chk("stat_ovf0", rd, 32'h0000_0101);
        apb_rd(32'h14, rd, er);
        chk("len0_055", rd, 32'h0000_0055);
        apb_wr(32'h04, 32'h0000_0101, 4'b1111, er, st);
        chk("irq_hold", irq, 1);
        @(negedge clk);
        chk("irq_fall", irq, 0);
        apb_rd(32'h04, rd, er);
        chk("stat_clr", rd, 0);

        pulse_done(4'b1000, 48'h7FF_000_000_000);
        @(negedge clk);
        paddr = BASE + 32'h04; pwdata = 32'h0000_0008; pstrb = 4'b1111;
        pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        encode_done = 4'b1000; byte_len = 48'h0AB_000_000_000;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; encode_done = '0;
        apb_rd(32'h04, rd, er);
        chk("w1c_race", rd, 32'h0000_0808);
        apb_rd(32'h2C, rd, er);
        chk("len3", rd, 32'h0000_00AB);
        chk("irq_ch3", irq, 1);

        @(negedge clk);
        paddr = BASE + 32'h10; pwdata = 32'h1234_5678; pstrb = 4'b1111;
        pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_en_or_de", en_or_de, 0);
        chk("mid_rst_tile_w", tile_width, 0);
        apb_rd(32'h10, rd, er);
        chk("mid_rst_cfg0", rd, 0);
        apb_rd(32'h04, rd, er);
        chk("mid_rst_stat", rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
